main_mem_ctrl: RTL and testbench
================================

# main_mem_ctrl

Backing-store memory controller that sits directly downstream of the cache block. It serves cache line fills on a miss and write-throughs from the cache's miss/write state machine over a single-outstanding req/ack handshake. It models a slow main memory by inserting a programmable number of wait states. It exposes the first eight words as debug outputs for bench and board observation.

## Interface
- ADDR_W, 8, address width
- DATA_W, 8, data width
- DEPTH, 16, implemented words; legal addresses 0..DEPTH-1
- WAIT_STATES, 3, idle cycles between request acceptance and ack (0 allowed)

Ports:
- clk  in  1  system clock, rising-edge
- clr  in  1  reset, asynchronous, active-low
- req  in  1  access request from cache, level, sampled in IDLE
- rw  in  1  1 = write, 0 = read
- addr  in  ADDR_W  word address
- wdata  in  DATA_W  write data
- rdata  out  DATA_W  read data, valid when ack=1, held until next ack
- ack  out  1  one-cycle completion pulse
- err  out  1  pulses with ack when addr >= DEPTH
- busy  out  1  high from acceptance through the ack cycle
- ram0..ram7  out  DATA_W each  debug: contents of words 0..7

## Operation
- One clock; reset is asynchronous and active-low.
- clr=0 forces the following immediately, with no clock required: state IDLE, counter 0, all DEPTH words 0, rdata=0, ack=0, err=0, busy=0.
- FSM states:
  - IDLE: req=1 latches addr/rw/wdata into request registers. Goes to WAIT if WAIT_STATES>0, else ACK.
  - WAIT: counter loaded with WAIT_STATES-1 and decremented each cycle. At 0, goes to ACK.
  - ACK: ack=1 for exactly one cycle, then returns to IDLE.
- The access is performed on the edge that enters ACK:
  - Write: mem[addr] <= wdata.
  - Read: rdata <= mem[addr].
- Out-of-range address (addr >= DEPTH): no write occurs, rdata <= 0, err=1 alongside ack.
- Input changes after acceptance are ignored; latched values are used.
- req is ignored in WAIT and ACK.
- req still high in the IDLE cycle after ACK is accepted as a new request (back-to-back). The cache must drop req on the ack cycle to avoid a repeat access.
- Only one request is outstanding at a time. No queueing.
- ram0..ram7 are continuous reads of mem[0..7]. A write is visible on them the cycle after the write edge.

## Timing
- req high at edge N (IDLE) → busy high after N; ack/rdata/err valid after edge N+WAIT_STATES+1; busy low after edge N+WAIT_STATES+2.
- WAIT_STATES=0 → ack after edge N+1 (1-cycle latency).
- Minimum request spacing is WAIT_STATES+2 cycles.
- Reset asserted mid-request: request aborted, no write, no ack. The first legal req is at the first rising edge after clr returns high.
- rdata is unchanged by writes and by cycles without ack.

## Structure
- Shared package mem_pkg contains:
  - State encoding localparams (IDLE, WAIT, ACK; 2-bit).
  - ADDR_W/DATA_W defaults, shared with the cache block.
  - rw encoding constants RW_READ=0 and RW_WRITE=1.
- One sub-module, mem_wait_cnt: loadable down-counter with load and zero flag, async active-low clear. Reused later for cache fill sequencing.
- Storage is a register array, because of the reset-to-zero requirement.

## Test plan
- Reset: drive clr=0 mid-WAIT of a write to addr 2. After release, ram2=0, ack never pulsed, and ram0..ram7 all 0.
- Write then read, WAIT_STATES=3: write 8'h80 to addr 0 with req at edge N → ack after N+4, ram0=8'h80 after N+5. Read addr 0 → rdata=8'h80 with ack.
- Back-to-back: hold req=1 across two writes (addr 2=8'hC0, addr 3=8'hE0). Two acks occur 5 cycles apart; ram2=8'hC0 and ram3=8'hE0.
- Input hold-off: change addr and wdata during WAIT. The write lands at the originally latched address and data only.
- Out-of-range: read addr 8'h20 with DEPTH=16 → ack=1, err=1, rdata=0. Write to it leaves all words unchanged.
- Zero wait states: WAIT_STATES=0, read addr 3 → ack on the first edge after acceptance, rdata=8'hE0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the main memory controller and the cache block.
// Holds the controller state encoding, the default bus widths and the
// rw encoding used on the cache/memory handshake.
package mem_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    WAIT = ST_WAIT,
    ACK  = ST_ACK
  } state_t;

endpackage

// File: rtl/main_mem_ctrl_if.sv
// Cache <-> main memory request/acknowledge bus.
//   req/rw/addr/wdata : request side, driven by the cache (master)
//   rdata/ack/err/busy: completion side, driven by the memory (slave)
interface main_mem_ctrl_if
  import mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              req;
  logic              rw;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;
  logic              err;
  logic              busy;

  modport master (output req, rw, addr, wdata, input rdata, ack, err, busy);
  modport slave  (input req, rw, addr, wdata, output rdata, ack, err, busy);
endinterface

// File: rtl/mem_wait_cnt.sv
// Loadable down-counter with a zero flag.
//   clk, clr  : clock, asynchronous active-low clear
//   load      : load load_val (has priority over dec)
//   dec       : decrement by one, saturating at zero
//   zero      : count is zero
module mem_wait_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);
  logic [W-1:0] count;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);
endmodule

// File: rtl/main_mem_ctrl.sv
// Backing-store memory controller with programmable wait states.
//   clk         : system clock, rising edge
//   clr         : asynchronous active-low reset
//   bus         : slave side of the cache request/ack bus
//   ram0..ram7  : debug view of words 0..7
// Timeline for a request accepted at edge N: WAIT for WAIT_STATES cycles,
// one ACK cycle, then the access and the ack pulse register on the edge
// leaving ACK (N+WAIT_STATES+1). The ack cycle coincides with IDLE, so a
// req still held there is accepted on the next edge (WAIT_STATES+2 spacing).
module main_mem_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 3
) (
  input  logic              clk,
  input  logic              clr,
  main_mem_ctrl_if.slave    bus,
  output logic [DATA_W-1:0] ram0,
  output logic [DATA_W-1:0] ram1,
  output logic [DATA_W-1:0] ram2,
  output logic [DATA_W-1:0] ram3,
  output logic [DATA_W-1:0] ram4,
  output logic [DATA_W-1:0] ram5,
  output logic [DATA_W-1:0] ram6,
  output logic [DATA_W-1:0] ram7
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD =
    CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
  localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W + 1)'(DEPTH);

  state_t            state;
  logic              req_rw;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [DATA_W-1:0] rdata_q;
  logic              ack_q;
  logic              err_q;
  logic              busy_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic cnt_load;
  logic cnt_dec;
  logic cnt_zero;
  logic in_range;

  // NOTE: every signal written in always_comb gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    if (state == IDLE && bus.req && WAIT_STATES > 0) cnt_load = 1'b1;
    if (state == WAIT && !cnt_zero)                  cnt_dec  = 1'b1;
  end

  mem_wait_cnt #(.W(CNT_W)) u_wait_cnt (
    .clk      (clk),
    .clr      (clr),
    .load     (cnt_load),
    .load_val (CNT_LOAD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  assign in_range = ({1'b0, req_addr} < DEPTH_A);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state     <= IDLE;
      req_rw    <= RW_READ;
      req_addr  <= '0;
      req_wdata <= '0;
      rdata_q   <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      // NOTE: the array must read zero straight out of reset, so it is
      // built from flops with an async clear rather than a RAM macro.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      unique case (state)
        IDLE: begin
          busy_q <= bus.req;
          if (bus.req) begin
            req_rw    <= bus.rw;
            req_addr  <= bus.addr;
            req_wdata <= bus.wdata;
            state     <= (WAIT_STATES > 0) ? WAIT : ACK;
          end
        end
        WAIT: begin
          if (cnt_zero) state <= ACK;
        end
        ACK: begin
          state <= IDLE;
          ack_q <= 1'b1;
          err_q <= !in_range;
          if (!in_range) begin
            rdata_q <= '0;
          end else if (req_rw == RW_WRITE) begin
            mem[req_addr[IDX_W-1:0]] <= req_wdata;
          end else begin
            rdata_q <= mem[req_addr[IDX_W-1:0]];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.ack   = ack_q;
  assign bus.err   = err_q;
  assign bus.busy  = busy_q;

  assign ram0 = mem[0];
  assign ram1 = mem[1];
  assign ram2 = mem[2];
  assign ram3 = mem[3];
  assign ram4 = mem[4];
  assign ram5 = mem[5];
  assign ram6 = mem[6];
  assign ram7 = mem[7];
endmodule

// File: tb/tb_main_mem_ctrl.sv
// Bench for main_mem_ctrl: instance 0 uses 3 wait states, instance 1 uses 0.
// Expected completions (rdata, err, ack cycle) are queued when a request is
// accepted and compared when ack is seen on the falling edge.
module tb_main_mem_ctrl;
  typedef struct {
    logic [7:0] rdata;
    logic       err;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic clr = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  logic       req_d   [2];
  logic       rw_d    [2];
  logic [7:0] addr_d  [2];
  logic [7:0] wdata_d [2];
  logic [7:0] rdata_o [2];
  logic       ack_o   [2];
  logic       err_o   [2];
  logic       busy_o  [2];
  logic [7:0] ram_a   [2][8];

  logic [7:0] mdl     [2][16];
  logic [7:0] last_rd [2];
  exp_t       q0 [$];
  exp_t       q1 [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  main_mem_ctrl_if #(.ADDR_W(8), .DATA_W(8)) bus3 ();
  main_mem_ctrl_if #(.ADDR_W(8), .DATA_W(8)) bus0 ();

  assign bus3.req = req_d[0];  assign bus3.rw = rw_d[0];
  assign bus3.addr = addr_d[0]; assign bus3.wdata = wdata_d[0];
  assign bus0.req = req_d[1];  assign bus0.rw = rw_d[1];
  assign bus0.addr = addr_d[1]; assign bus0.wdata = wdata_d[1];
  assign rdata_o[0] = bus3.rdata; assign ack_o[0] = bus3.ack;
  assign err_o[0]   = bus3.err;   assign busy_o[0] = bus3.busy;
  assign rdata_o[1] = bus0.rdata; assign ack_o[1] = bus0.ack;
  assign err_o[1]   = bus0.err;   assign busy_o[1] = bus0.busy;

  main_mem_ctrl #(.ADDR_W(8), .DATA_W(8), .DEPTH(16), .WAIT_STATES(3)) u_dut3 (
    .clk(clk), .clr(clr), .bus(bus3.slave),
    .ram0(ram_a[0][0]), .ram1(ram_a[0][1]), .ram2(ram_a[0][2]), .ram3(ram_a[0][3]),
    .ram4(ram_a[0][4]), .ram5(ram_a[0][5]), .ram6(ram_a[0][6]), .ram7(ram_a[0][7])
  );

  main_mem_ctrl #(.ADDR_W(8), .DATA_W(8), .DEPTH(16), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .clr(clr), .bus(bus0.slave),
    .ram0(ram_a[1][0]), .ram1(ram_a[1][1]), .ram2(ram_a[1][2]), .ram3(ram_a[1][3]),
    .ram4(ram_a[1][4]), .ram5(ram_a[1][5]), .ram6(ram_a[1][6]), .ram7(ram_a[1][7])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference behaviour: updates the word model and returns the completion
  // the memory should report for this request.
  function automatic exp_t predict(input int s, input bit w, input logic [7:0] a,
                                   input logic [7:0] d, input int acc);
    exp_t e;
    e.cyc = acc + ((s == 0) ? 3 : 0) + 1;
    e.err = (a >= 8'd16);
    if (e.err)  last_rd[s] = 8'h00;
    else if (w) mdl[s][a[3:0]] = d;
    else        last_rd[s] = mdl[s][a[3:0]];
    e.rdata = last_rd[s];
    return e;
  endfunction

  task automatic push_exp(input int s, input exp_t e);
    if (s == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  function automatic int qsize(input int s);
    return (s == 0) ? q0.size() : q1.size();
  endfunction

  // Completion monitor for both instances.
  always @(negedge clk) begin
    exp_t e;
    if (clr && ack_o[0]) begin
      if (q0.size() == 0) check("ws3_unexpected_ack", 1, 0);
      else begin
        e = q0.pop_front();
        check("ws3_rdata", rdata_o[0], e.rdata);
        check("ws3_err", err_o[0], e.err);
        check("ws3_ack_cycle", cyc, e.cyc);
      end
    end
    if (clr && ack_o[1]) begin
      if (q1.size() == 0) check("ws0_unexpected_ack", 1, 0);
      else begin
        e = q1.pop_front();
        check("ws0_rdata", rdata_o[1], e.rdata);
        check("ws0_err", err_o[1], e.err);
        check("ws0_ack_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic wait_idle(input int s);
    bit done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (qsize(s) == 0 && busy_o[s] == 1'b0) done = 1'b1;
    end
    if (!done) check("idle_timeout", 0, 1);
  endtask

  // Call right after a falling edge with the instance idle. Inputs are
  // scrambled after acceptance so only latched values may be used.
  task automatic issue(input int s, input bit w, input logic [7:0] a, input logic [7:0] d);
    int acc;
    req_d[s] = 1'b1; rw_d[s] = w; addr_d[s] = a; wdata_d[s] = d;
    @(posedge clk); #1 acc = cyc;
    push_exp(s, predict(s, w, a, d, acc));
    @(negedge clk);
    req_d[s] = 1'b0; rw_d[s] = ~w;
    addr_d[s] = 8'($urandom_range(0, 7)); wdata_d[s] = 8'($urandom);
    wait_idle(s);
  endtask

  task automatic check_rams(input int s, input string tag);
    for (int i = 0; i < 8; i++) check(tag, ram_a[s][i], mdl[s][i]);
  endtask

  initial begin
    int acc;
    for (int s = 0; s < 2; s++) begin
      req_d[s] = 1'b0; rw_d[s] = 1'b0; addr_d[s] = '0; wdata_d[s] = '0;
      last_rd[s] = '0;
      for (int i = 0; i < 16; i++) mdl[s][i] = '0;
    end

    // Reset state, checked while clr is still low.
    #12;
    for (int s = 0; s < 2; s++) begin
      check("rst_busy", busy_o[s], 0);
      check("rst_ack", ack_o[s], 0);
      check("rst_err", err_o[s], 0);
      check("rst_rdata", rdata_o[s], 0);
      check_rams(s, "rst_ram");
    end
    @(negedge clk) clr = 1'b1;

    // Reset in the middle of a write's wait period aborts it.
    @(negedge clk);
    req_d[0] = 1'b1; rw_d[0] = 1'b1; addr_d[0] = 8'd2; wdata_d[0] = 8'h55;
    @(posedge clk);
    @(negedge clk) req_d[0] = 1'b0;
    @(posedge clk);
    @(negedge clk) clr = 1'b0;
    #1;
    check("abort_busy", busy_o[0], 0);
    check("abort_ack", ack_o[0], 0);
    @(negedge clk) clr = 1'b1;
    repeat (6) @(negedge clk);
    check_rams(0, "abort_ram");

    // Write then read back with three wait states.
    issue(0, 1'b1, 8'd0, 8'h80);
    check_rams(0, "wr0_ram");
    issue(0, 1'b0, 8'd0, 8'h00);

    // Back-to-back writes with req held; second accepted 5 edges later.
    req_d[0] = 1'b1; rw_d[0] = 1'b1; addr_d[0] = 8'd2; wdata_d[0] = 8'hC0;
    @(posedge clk); #1 acc = cyc;
    push_exp(0, predict(0, 1'b1, 8'd2, 8'hC0, acc));
    @(negedge clk);
    addr_d[0] = 8'd3; wdata_d[0] = 8'hE0;
    repeat (5) @(posedge clk);
    #1 acc = cyc;
    push_exp(0, predict(0, 1'b1, 8'd3, 8'hE0, acc));
    @(negedge clk) req_d[0] = 1'b0;
    wait_idle(0);
    check_rams(0, "b2b_ram");

    // Inputs changed during the wait period must not affect the write.
    issue(0, 1'b1, 8'd5, 8'h3C);
    check_rams(0, "holdoff_ram");

    // Out-of-range read and write.
    issue(0, 1'b0, 8'h20, 8'h00);
    issue(0, 1'b1, 8'h20, 8'h77);
    check_rams(0, "oor_ram");
    issue(0, 1'b0, 8'd3, 8'h00);
    issue(0, 1'b0, 8'd2, 8'h00);
    repeat (3) @(negedge clk);
    check("rdata_hold", rdata_o[0], last_rd[0]);

    // Zero wait states.
    issue(1, 1'b1, 8'd3, 8'hE0);
    issue(1, 1'b0, 8'd3, 8'h00);
    issue(1, 1'b0, 8'h10, 8'h00);
    issue(1, 1'b1, 8'd7, 8'h5A);
    check_rams(1, "ws0_ram");
    check("ws0_rdata_hold", rdata_o[1], last_rd[1]);

    check("ws3_queue_empty", q0.size(), 0);
    check("ws0_queue_empty", q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
